// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for sequencers that drive the 8-bit shift register stage.
// Holds the register's sel encoding, the sequencer state type and the step-decode record.
package shift_seq_ctrl_pkg;

    // Same encoding the shift register decodes on its sel input.
    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_SHR3 = 2'b01;
    localparam logic [1:0] SEL_SHR2 = 2'b10;
    localparam logic [1:0] SEL_SHR1 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One greedy step: the code to drive, the amount left afterwards, and the shift applied.
    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] next_rem;
        logic [1:0] shamt;
    } step_t;

    function automatic step_t greedy_step(input logic [2:0] rem);
        step_t s;
        s = '{sel: SEL_LOAD, next_rem: 3'd0, shamt: 2'd0};
        if (rem >= 3'd3) begin
            s.sel      = SEL_SHR3;
            s.next_rem = rem - 3'd3;
            s.shamt    = 2'd3;
        end else if (rem == 3'd2) begin
            s.sel   = SEL_SHR2;
            s.shamt = 2'd2;
        end else if (rem == 3'd1) begin
            s.sel   = SEL_SHR1;
            s.shamt = 2'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_step_dec.sv
// Combinational greedy decoder: remaining right-shift amount -> one 3/2/1 step.
// Shared by any sequencer that drives the same shift register.
module shift_step_dec
    import shift_seq_ctrl_pkg::*;
(
    input  logic [2:0] rem,
    output logic [1:0] sel,
    output logic [2:0] next_rem,
    output logic [1:0] shamt
);

    step_t step;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        step     = greedy_step(rem);
        sel      = step.sel;
        next_rem = step.next_rem;
        shamt    = step.shamt;
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-bit shift register: loads a byte, then right-shifts it by a
// total amount in greedy 3/2/1 steps, keeping a shadow of the register contents.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [2:0] amount,
    output logic       busy,
    output logic       done,
    output logic [1:0] sel,
    output logic [7:0] sr_in,
    // Shadow of the register's out; named "expected" because "expect" is a reserved word.
    output logic [7:0] expected
);

    state_t     state;
    logic [2:0] rem;
    logic [7:0] shadow;

    logic [1:0] step_sel;
    logic [2:0] step_next_rem;
    logic [1:0] step_shamt;

    shift_step_dec u_step_dec (
        .rem      (rem),
        .sel      (step_sel),
        .next_rem (step_next_rem),
        .shamt    (step_shamt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            rem    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        shadow <= data_in;
                        rem    <= amount;
                        busy   <= 1'b1;
                        if (amount != 3'd0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shadow <= shadow >> step_shamt;
                    rem    <= step_next_rem;
                    if (step_next_rem == 3'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // The register has no hold code, so anything other than a shift step reloads the shadow.
    // During reset a zero load clears the register on the same edge as the sequencer.
    always_comb begin
        sel   = SEL_LOAD;
        sr_in = shadow;
        if (!rst_n) begin
            sr_in = '0;
        end else if (state == SHIFT) begin
            sel = step_sel;
        end else if (state == IDLE && start) begin
            sr_in = data_in;
        end
    end

    assign expected = shadow;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural model of the shift register.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic       busy;
    logic       done;
    logic [1:0] sel;
    logic [7:0] sr_in;
    logic [7:0] expected;

    logic [7:0] sr_out;
    bit         inv_on = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .amount   (amount),
        .busy     (busy),
        .done     (done),
        .sel      (sel),
        .sr_in    (sr_in),
        .expected (expected)
    );

    always #5 clk = ~clk;

    // Behavioural shift register: load on 00, zero-fill right shift by 3/2/1 on 01/10/11.
    always @(posedge clk) begin
        case (sel)
            2'b00:   sr_out <= sr_in;
            2'b01:   sr_out <= sr_out >> 3;
            2'b10:   sr_out <= sr_out >> 2;
            default: sr_out <= sr_out >> 1;
        endcase
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, want %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (inv_on) check("invariant_out_eq_expected", sr_out, expected);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int shamt_of(input logic [1:0] code);
        case (code)
            2'b01:   return 3;
            2'b10:   return 2;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    // Greedy decomposition of a total shift into 3/2/1 steps, code i at codes[2i+:2].
    task automatic model_steps(input logic [2:0] a, output logic [5:0] codes, output int n);
        int r;
        int step;
        r     = a;
        n     = 0;
        codes = '0;
        while (r > 0) begin
            step = (r >= 3) ? 3 : r;
            codes[2*n +: 2] = (step == 3) ? 2'b01 : (step == 2) ? 2'b10 : 2'b11;
            r -= step;
            n++;
        end
    endtask

    // Entered just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic [5:0] codes,
                          input int n, input logic [7:0] fin, input bit poke);
        logic [7:0] val;
        val     = d;
        start   = 1'b1;
        data_in = d;
        amount  = a;
        #1;
        check("accept_sel", 8'(sel), 8'h00);
        check("accept_sr_in", sr_in, d);
        check("accept_busy", 8'(busy), 8'h00);
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
        amount  = 3'($urandom);
        for (int i = 0; i < n; i++) begin
            if (poke && i == 0) begin
                start   = 1'b1;
                data_in = 8'h00;
            end
            #1;
            check("step_busy", 8'(busy), 8'h01);
            check("step_done", 8'(done), 8'h00);
            check("step_sel", 8'(sel), 8'(codes[2*i +: 2]));
            check("step_expected", expected, val);
            check("step_sr_in", sr_in, val);
            val = val >> shamt_of(codes[2*i +: 2]);
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("done_pulse", 8'(done), 8'h01);
        check("done_busy", 8'(busy), 8'h01);
        check("done_sel", 8'(sel), 8'h00);
        check("done_expected", expected, fin);
        check("done_sr_out", sr_out, fin);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("idle_busy", 8'(busy), 8'h00);
        check("idle_done", 8'(done), 8'h00);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic [5:0] codes;
        int         n;
        logic [7:0] fin;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [5:0] codes;
        int         n;
        logic [7:0] d;
        logic [2:0] a;

        vecs[0] = '{8'hB5, 3'd7, 6'b11_01_01, 3, 8'h01};
        vecs[1] = '{8'hFF, 3'd5, 6'b00_10_01, 2, 8'h07};
        vecs[2] = '{8'h3C, 3'd0, 6'b00_00_00, 0, 8'h3C};
        vecs[3] = '{8'h80, 3'd4, 6'b00_11_01, 2, 8'h08};
        vecs[4] = '{8'hA5, 3'd6, 6'b00_01_01, 2, 8'h02};
        vecs[5] = '{8'h81, 3'd1, 6'b00_00_11, 1, 8'h40};
        vecs[6] = '{8'h81, 3'd2, 6'b00_00_10, 1, 8'h20};
        vecs[7] = '{8'h81, 3'd3, 6'b00_00_01, 1, 8'h10};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 8'h5A;
        amount  = 3'd3;
        @(negedge clk);
        #1;
        check("reset_sel", 8'(sel), 8'h00);
        check("reset_sr_in", sr_in, 8'h00);
        @(negedge clk);
        #1;
        check("reset_busy", 8'(busy), 8'h00);
        check("reset_done", 8'(done), 8'h00);
        check("reset_expected", expected, 8'h00);
        check("reset_sr_out", sr_out, 8'h00);
        rst_n  = 1'b1;
        inv_on = 1'b1;
        @(negedge clk);
        #1;

        for (int v = 0; v < 8; v++)
            run_op(vecs[v].d, vecs[v].a, vecs[v].codes, vecs[v].n, vecs[v].fin, 1'b0);

        // start pulsed in SHIFT and DONE is ignored.
        run_op(8'hB5, 3'd7, 6'b11_01_01, 3, 8'h01, 1'b1);

        // Reset during the second step of amount=7 aborts with no done pulse.
        start   = 1'b1;
        data_in = 8'hB5;
        amount  = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sel", 8'(sel), 8'h00);
        check("abort_sr_in", sr_in, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_busy", 8'(busy), 8'h00);
        check("abort_done", 8'(done), 8'h00);
        check("abort_expected", expected, 8'h00);
        check("abort_sr_out", sr_out, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", 8'(done), 8'h00);
            check("abort_idle_busy", 8'(busy), 8'h00);
        end

        // Long IDLE after a completed op: register holds via shadow reload.
        run_op(8'hC3, 3'd2, 6'b00_00_10, 1, 8'h30, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("hold_sel", 8'(sel), 8'h00);
            check("hold_sr_in", sr_in, 8'h30);
            check("hold_sr_out", sr_out, 8'h30);
        end

        for (int r = 0; r < 40; r++) begin
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            model_steps(a, codes, n);
            run_op(d, a, codes, n, d >> a, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
